axi_wr_ctrl: RTL and testbench
==============================

Name: axi_wr_ctrl

Overview:
- Write-path sequencer between the per-beat write request FIFO and the AXI4 master write port toward memory.
- Takes the head FIFO entry's address/control fields and issues one AW transfer. Then drains the burst's beats from the FIFO onto W, waits for B, and returns the response upstream.
- One outstanding burst at a time.
- Detects burst-length mismatches and missing B responses.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 64, data width; strobe width is DATA_WIDTH/8.
- ID_WIDTH, 4, transaction ID width.
- B_TIMEOUT, 1024, cycles to wait in WAIT_B before forcing an error response; minimum 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ent_valid  in  1  FIFO head entry valid (FIFO not empty)
- ent_ready  out  1  pop FIFO head entry
- ent_awaddr  in  ADDR_WIDTH  burst start address (sampled from the first beat only)
- ent_awid  in  ID_WIDTH  burst ID (first beat only)
- ent_awburst  in  2  burst type (first beat only)
- ent_awsize  in  3  beat size (first beat only)
- ent_awlen  in  8  beats minus 1 (first beat only)
- ent_wdata  in  DATA_WIDTH  beat data
- ent_wstrb  in  DATA_WIDTH/8  beat strobes
- ent_wlast  in  1  upstream last-beat marker
- m_awvalid/m_awready  out/in  1  AXI AW handshake
- m_awaddr, m_awid, m_awburst, m_awsize, m_awlen  out  as ent_*  registered AW fields
- m_wvalid/m_wready  out/in  1  AXI W handshake
- m_wdata, m_wstrb  out  DATA_WIDTH, DATA_WIDTH/8  beat data/strobes
- m_wlast  out  1  last beat, generated internally
- m_bvalid/m_bready  in/out  1  AXI B handshake
- m_bid, m_bresp  in  ID_WIDTH, 2  response fields
- s_bvalid/s_bready  out/in  1  upstream response handshake
- s_bid, s_bresp  out  ID_WIDTH, 2  response returned upstream
- busy  out  1  state != IDLE
- len_err  out  1  sticky: ent_wlast disagreed with the internal beat count
- tmo_err  out  1  sticky: B timeout occurred

Behaviour:
- Reset: state=IDLE; all valid/ready outputs 0; AW fields, s_bid, s_bresp, beat_cnt, tmo_cnt = 0; len_err=tmo_err=0. Reset mid-burst abandons the burst: no further AW/W/B activity, and the FIFO is not popped.
- IDLE: if ent_valid=1, capture ent_aw* into the AW registers and go to ADDR next cycle. Nothing is popped.
- ADDR: m_awvalid=1 and AW fields held stable until m_awready. On the handshake, clear beat_cnt and go to DATA. AW-to-W minimum latency is 1 cycle.
- DATA:
  - m_wvalid=ent_valid; m_wdata/m_wstrb driven combinationally from the head entry; ent_ready=m_wready.
  - m_wlast=(beat_cnt==awlen_q).
  - On each W handshake: pop the entry and increment beat_cnt (8-bit).
  - If ent_wlast!=m_wlast on a handshake beat, set len_err. The internal count always governs m_wlast.
  - After the m_wlast beat, go to WAIT_B.
  - m_wvalid never asserts outside DATA; ent_ready=0 in all other states.
- WAIT_B:
  - m_bready=1; tmo_cnt increments each cycle.
  - On m_bvalid: latch s_bid=m_bid and s_bresp=m_bresp, then go to RESP.
  - If tmo_cnt reaches B_TIMEOUT-1 with no m_bvalid: set tmo_err, s_bid=awid_q, s_bresp=2'b10 (SLVERR), go to RESP.
  - If m_bvalid arrives on the timeout cycle, the real response wins and tmo_err is not set.
- RESP: s_bvalid=1 with fields held until s_bready, then return to IDLE. A new AW is issued at earliest 2 cycles after the s_bready handshake (IDLE capture, then ADDR).
- m_bready=0 outside WAIT_B. A stray m_bvalid in other states is ignored.
- len_err and tmo_err are cleared only by reset.
- Unknown state encoding recovers to IDLE.

Test Plan:
- Single-beat burst: awlen=0, addr=0x1000, id=3; slave ready every cycle, bresp=0 -> one AW, one W with m_wlast=1, s_bvalid with s_bid=3, s_bresp=0, exactly one FIFO pop, len_err=0.
- 4-beat burst: awlen=3, data 0xA..0xD; m_wready toggles 1/0 -> 4 W handshakes in order, m_wlast only on 0xD, AW fields stable throughout, 4 pops.
- Backpressure: m_awready low 5 cycles, then s_bready low 3 cycles -> m_awvalid held 6 cycles with stable fields, s_bvalid held 4 cycles, no pop before AW accept.
- Length mismatch: awlen=1 with ent_wlast=1 on beat 0 -> len_err=1 after beat 0, controller still sends 2 beats, m_wlast on beat 1.
- Timeout: B_TIMEOUT=16, m_bvalid never asserted -> after 16 cycles in WAIT_B, tmo_err=1, s_bresp=2'b10, s_bid=awid, then IDLE; next burst proceeds normally.
- Reset mid-DATA after beat 1 of 4 -> all outputs return to reset values immediately, no further pops, next burst begins at ADDR from the new FIFO head.

Source files
------------

// File: rtl/axi_wr_ctrl.sv
// AXI4 write-path sequencer: turns per-beat FIFO entries into one AW/W/B burst at a
// time and hands the write response back upstream, flagging length and B-timeout faults.
//
// state  | meaning
// IDLE   | wait for a FIFO head entry, capture its AW fields (no pop)
// ADDR   | m_awvalid held with stable fields until m_awready
// DATA   | stream head entries onto W, pop on each W handshake
// WAIT_B | m_bready high, wait for B or the timeout
// RESP   | s_bvalid held with stable fields until s_bready
module axi_wr_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int B_TIMEOUT  = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ent_valid,
  output logic                    ent_ready,
  input  logic [ADDR_WIDTH-1:0]   ent_awaddr,
  input  logic [ID_WIDTH-1:0]     ent_awid,
  input  logic [1:0]              ent_awburst,
  input  logic [2:0]              ent_awsize,
  input  logic [7:0]              ent_awlen,
  input  logic [DATA_WIDTH-1:0]   ent_wdata,
  input  logic [DATA_WIDTH/8-1:0] ent_wstrb,
  input  logic                    ent_wlast,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [ID_WIDTH-1:0]     m_awid,
  output logic [1:0]              m_awburst,
  output logic [2:0]              m_awsize,
  output logic [7:0]              m_awlen,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [ID_WIDTH-1:0]     m_bid,
  input  logic [1:0]              m_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    busy,
  output logic                    len_err,
  output logic                    tmo_err
);

  localparam int TMO_WIDTH = $clog2(B_TIMEOUT);
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(B_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_WAIT_B = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t               state;
  logic [7:0]           beat_cnt;
  logic [TMO_WIDTH-1:0] tmo_cnt;
  logic                 last_beat;
  logic                 w_hs;

  // W data is a straight pass-through of the FIFO head; only the handshake is gated.
  assign last_beat = (beat_cnt == m_awlen);
  assign m_awvalid = (state == S_ADDR);
  assign m_wvalid  = (state == S_DATA) && ent_valid;
  assign ent_ready = (state == S_DATA) && m_wready;
  assign m_wdata   = ent_wdata;
  assign m_wstrb   = ent_wstrb;
  assign m_wlast   = (state == S_DATA) && last_beat;
  assign m_bready  = (state == S_WAIT_B);
  assign s_bvalid  = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign w_hs      = m_wvalid && m_wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      m_awaddr  <= '0;
      m_awid    <= '0;
      m_awburst <= '0;
      m_awsize  <= '0;
      m_awlen   <= '0;
      s_bid     <= '0;
      s_bresp   <= '0;
      beat_cnt  <= '0;
      tmo_cnt   <= '0;
      len_err   <= 1'b0;
      tmo_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ent_valid) begin
            m_awaddr  <= ent_awaddr;
            m_awid    <= ent_awid;
            m_awburst <= ent_awburst;
            m_awsize  <= ent_awsize;
            m_awlen   <= ent_awlen;
            state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (m_awready) begin
            beat_cnt <= '0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            // the internal count is authoritative; a disagreeing upstream marker is only reported
            if (ent_wlast != last_beat) len_err <= 1'b1;
            if (last_beat) begin
              tmo_cnt <= '0;
              state   <= S_WAIT_B;
            end
          end
        end
        S_WAIT_B: begin
          tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
          if (m_bvalid) begin
            s_bid   <= m_bid;
            s_bresp <= m_bresp;
            state   <= S_RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_err <= 1'b1;
            s_bid   <= m_awid;
            s_bresp <= 2'b10;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (s_bready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_ctrl.sv
// Bench for axi_wr_ctrl: a FIFO model feeds bursts, an AXI slave model answers, and
// a transaction scoreboard built from the pushed bursts checks AW/W/B and the error flags.
`timescale 1ns/1ps
module tb_axi_wr_ctrl;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int SW = DW / 8;
  localparam int BT = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [1:0]    burst;
    logic [2:0]    size;
    logic [7:0]    len;
  } aw_t;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } w_t;
  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ent_valid, ent_ready;
  logic [AW-1:0] ent_awaddr;
  logic [IW-1:0] ent_awid;
  logic [1:0] ent_awburst;
  logic [2:0] ent_awsize;
  logic [7:0] ent_awlen;
  logic [DW-1:0] ent_wdata;
  logic [SW-1:0] ent_wstrb;
  logic ent_wlast;
  logic m_awvalid;
  logic m_awready = 1'b0;
  logic [AW-1:0] m_awaddr;
  logic [IW-1:0] m_awid;
  logic [1:0] m_awburst;
  logic [2:0] m_awsize;
  logic [7:0] m_awlen;
  logic m_wvalid;
  logic m_wready = 1'b0;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic m_wlast;
  logic m_bvalid = 1'b0;
  logic m_bready;
  logic [IW-1:0] m_bid = '0;
  logic [1:0] m_bresp = '0;
  logic s_bvalid;
  logic s_bready = 1'b0;
  logic [IW-1:0] s_bid;
  logic [1:0] s_bresp;
  logic busy, len_err, tmo_err;

  axi_wr_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .B_TIMEOUT(BT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ent_valid(ent_valid), .ent_ready(ent_ready), .ent_awaddr(ent_awaddr), .ent_awid(ent_awid),
    .ent_awburst(ent_awburst), .ent_awsize(ent_awsize), .ent_awlen(ent_awlen),
    .ent_wdata(ent_wdata), .ent_wstrb(ent_wstrb), .ent_wlast(ent_wlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awburst(m_awburst), .m_awsize(m_awsize), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .busy(busy), .len_err(len_err), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  // upstream FIFO model: a ring of entries, popped one cycle after each observed handshake
  logic [AW-1:0] f_addr [256];
  logic [IW-1:0] f_id [256];
  logic [1:0] f_burst [256];
  logic [2:0] f_size [256];
  logic [7:0] f_len [256];
  logic [DW-1:0] f_data [256];
  logic [SW-1:0] f_strb [256];
  logic f_last [256];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int pops_applied = 0;
  int flush_req = 0;
  int flush_done = 0;
  logic [7:0] rd_idx;
  assign rd_idx      = rd_cnt[7:0];
  assign ent_valid   = (rd_cnt != wr_cnt);
  assign ent_awaddr  = f_addr[rd_idx];
  assign ent_awid    = f_id[rd_idx];
  assign ent_awburst = f_burst[rd_idx];
  assign ent_awsize  = f_size[rd_idx];
  assign ent_awlen   = f_len[rd_idx];
  assign ent_wdata   = f_data[rd_idx];
  assign ent_wstrb   = f_strb[rd_idx];
  assign ent_wlast   = f_last[rd_idx];

  // slave response plan, one entry per tracked burst
  logic b_drop [256];
  logic [IW-1:0] b_id [256];
  logic [1:0] b_resp [256];
  int n_plan = 0;
  int b_taken = 0;
  int b_sent = 0;
  int b_wait = 0;

  int unsigned aw_pct = 100, w_pct = 100, s_pct = 100;
  bit aw_hold = 0, s_hold = 0, w_toggle = 0;

  // observations, written only by the monitor
  aw_t got_aw[$];
  w_t got_w[$];
  b_t got_b[$];
  aw_t cur_aw, aw_prev;
  b_t cur_s, s_prev;
  bit aw_wait = 0, s_wait = 0;
  int n_pops = 0, wlast_cnt = 0, bhs_cnt = 0;
  int aw_run = 0, aw_hold_last = 0, s_run = 0, s_hold_last = 0, b_run = 0, bready_last = 0;
  int aw_unstable = 0, s_unstable = 0, aw_drift = 0;

  // expectations, written only by the test tasks
  aw_t exp_aw[$];
  w_t exp_w[$];
  b_t exp_b[$];
  int ck_aw = 0, ck_w = 0, ck_b = 0, off_aw = 0, off_w = 0, off_b = 0;
  int exp_pops = 0;
  logic exp_len_err = 1'b0, exp_tmo_err = 1'b0;

  int errors = 0;
  int checks = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      aw_run = 0; s_run = 0; b_run = 0; aw_wait = 0; s_wait = 0;
    end else begin
      cur_aw = {m_awaddr, m_awid, m_awburst, m_awsize, m_awlen};
      cur_s  = {s_bid, s_bresp};
      if (aw_wait && (!m_awvalid || cur_aw != aw_prev)) aw_unstable++;
      aw_wait = m_awvalid && !m_awready;
      aw_prev = cur_aw;
      if (s_wait && (!s_bvalid || cur_s != s_prev)) s_unstable++;
      s_wait = s_bvalid && !s_bready;
      s_prev = cur_s;
      if (m_awvalid) aw_run++;
      if (m_awvalid && m_awready) begin
        got_aw.push_back(cur_aw);
        aw_hold_last = aw_run;
        aw_run = 0;
      end
      if (ent_valid && ent_ready) n_pops++;
      if (m_wvalid && m_wready) begin
        got_w.push_back({m_wdata, m_wstrb, m_wlast});
        if (got_aw.size() > 0 && cur_aw != got_aw[$]) aw_drift++;
        if (m_wlast) wlast_cnt++;
      end
      if (m_bvalid && m_bready) bhs_cnt++;
      if (m_bready) b_run++;
      else if (b_run != 0) begin bready_last = b_run; b_run = 0; end
      if (s_bvalid) s_run++;
      if (s_bvalid && s_bready) begin
        got_b.push_back(cur_s);
        s_hold_last = s_run;
        s_run = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (flush_req != flush_done) begin
      rd_cnt = wr_cnt;
      flush_done = flush_req;
      pops_applied = n_pops;
    end else begin
      rd_cnt = rd_cnt + (n_pops - pops_applied);
      pops_applied = n_pops;
    end
    if (m_bvalid && bhs_cnt >= b_sent) m_bvalid = 1'b0;
    if (!m_bvalid && b_taken < wlast_cnt) begin
      if (b_drop[b_taken[7:0]]) b_taken++;
      else if (b_wait > 0) b_wait--;
      else begin
        m_bvalid = 1'b1;
        m_bid    = b_id[b_taken[7:0]];
        m_bresp  = b_resp[b_taken[7:0]];
        b_taken++;
        b_sent++;
        b_wait = int'($urandom_range(3));
      end
    end
    m_awready = !aw_hold && ($urandom_range(99) < aw_pct);
    m_wready  = w_toggle ? !m_wready : ($urandom_range(99) < w_pct);
    s_bready  = !s_hold && ($urandom_range(99) < s_pct);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // bad_beat flips the upstream wlast marker on that beat; force_resp >= 0 makes the slave echo the AW id
  task automatic push_burst(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [7:0] len,
                            input int bad_beat, input bit drop, input bit track, input bit seq_data,
                            input int force_resp);
    logic [1:0] bu;
    logic [2:0] sz;
    logic [7:0] k;
    aw_t a;
    w_t w;
    b_t e;
    bu = 2'($urandom);
    sz = 3'($urandom);
    for (int i = 0; i <= int'(len); i++) begin
      k = wr_cnt[7:0];
      f_addr[k] = addr; f_id[k] = id; f_burst[k] = bu; f_size[k] = sz; f_len[k] = len;
      f_data[k] = seq_data ? DW'(10 + i) : {$urandom, $urandom};
      f_strb[k] = SW'($urandom);
      f_last[k] = (i == int'(len)) ^ (i == bad_beat);
      if (track) begin
        w.data = f_data[k]; w.strb = f_strb[k]; w.last = (i == int'(len));
        exp_w.push_back(w);
        exp_pops++;
      end
      wr_cnt++;
    end
    if (track) begin
      a.addr = addr; a.id = id; a.burst = bu; a.size = sz; a.len = len;
      exp_aw.push_back(a);
      b_drop[n_plan[7:0]] = drop;
      b_id[n_plan[7:0]]   = (force_resp >= 0) ? id : IW'($urandom);
      b_resp[n_plan[7:0]] = (force_resp >= 0) ? 2'(force_resp) : 2'($urandom);
      e.id   = drop ? id : b_id[n_plan[7:0]];
      e.resp = drop ? 2'b10 : b_resp[n_plan[7:0]];
      exp_b.push_back(e);
      n_plan++;
      if (bad_beat >= 0 && bad_beat <= int'(len)) exp_len_err = 1'b1;
      if (drop) exp_tmo_err = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_traffic(input string tag);
    int budget;
    budget = 4000;
    while ((got_b.size() - off_b) < exp_b.size() && budget > 0) begin tick(); budget--; end
    repeat (4) tick();
    checks++;
    if (budget == 0) begin errors++; $display("FAIL %s resp_wait got=%0d want=%0d", tag, got_b.size() - off_b, exp_b.size()); end
    for (int i = ck_aw; i < exp_aw.size(); i++) begin
      checks++;
      if (i + off_aw >= got_aw.size()) begin errors++; $display("FAIL %s aw[%0d] got=none want=%h", tag, i, exp_aw[i]); end
      else if (got_aw[i + off_aw] !== exp_aw[i]) begin errors++; $display("FAIL %s aw[%0d] got=%h want=%h", tag, i, got_aw[i + off_aw], exp_aw[i]); end
    end
    for (int i = ck_w; i < exp_w.size(); i++) begin
      checks++;
      if (i + off_w >= got_w.size()) begin errors++; $display("FAIL %s w[%0d] got=none want=%h", tag, i, exp_w[i]); end
      else if (got_w[i + off_w] !== exp_w[i]) begin errors++; $display("FAIL %s w[%0d] got=%h want=%h", tag, i, got_w[i + off_w], exp_w[i]); end
    end
    for (int i = ck_b; i < exp_b.size(); i++) begin
      checks++;
      if (i + off_b >= got_b.size()) begin errors++; $display("FAIL %s b[%0d] got=none want=%h", tag, i, exp_b[i]); end
      else if (got_b[i + off_b] !== exp_b[i]) begin errors++; $display("FAIL %s b[%0d] got=%h want=%h", tag, i, got_b[i + off_b], exp_b[i]); end
    end
    ck_aw = exp_aw.size(); ck_w = exp_w.size(); ck_b = exp_b.size();
    checks++;
    if (got_aw.size() != exp_aw.size() + off_aw || got_w.size() != exp_w.size() + off_w || got_b.size() != exp_b.size() + off_b) begin
      errors++;
      $display("FAIL %s counts got aw/w/b=%0d/%0d/%0d want=%0d/%0d/%0d", tag, got_aw.size() - off_aw,
               got_w.size() - off_w, got_b.size() - off_b, exp_aw.size(), exp_w.size(), exp_b.size());
    end
    checks++;
    if (n_pops != exp_pops) begin errors++; $display("FAIL %s pops got=%0d want=%0d", tag, n_pops, exp_pops); end
    checks++;
    if (len_err !== exp_len_err || tmo_err !== exp_tmo_err) begin
      errors++; $display("FAIL %s err_flags got len/tmo=%b/%b want=%b/%b", tag, len_err, tmo_err, exp_len_err, exp_tmo_err);
    end
    checks++;
    if (aw_unstable != 0 || s_unstable != 0 || aw_drift != 0) begin
      errors++; $display("FAIL %s stability got aw/s/drift=%0d/%0d/%0d want=0/0/0", tag, aw_unstable, s_unstable, aw_drift);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s idle_busy got=%b want=0", tag, busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_awvalid, m_wvalid, m_wlast, ent_ready, m_bready, s_bvalid, busy, len_err, tmo_err} !== 9'b0) begin
      errors++; $display("FAIL reset ctrl got=%b want=000000000", {m_awvalid, m_wvalid, m_wlast, ent_ready, m_bready, s_bvalid, busy, len_err, tmo_err});
    end
    checks++;
    if ({m_awaddr, m_awid, m_awburst, m_awsize, m_awlen, s_bid, s_bresp} !== '0) begin
      errors++; $display("FAIL reset fields got awaddr=%h awid=%h awlen=%h s_bid=%h s_bresp=%h want=0", m_awaddr, m_awid, m_awlen, s_bid, s_bresp);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || m_awvalid !== 1'b0) begin errors++; $display("FAIL reset idle_empty got busy=%b awvalid=%b want=0", busy, m_awvalid); end
  endtask

  task automatic test_single_beat();
    push_burst(32'h1000, 4'd3, 8'd0, -1, 1'b0, 1'b1, 1'b0, 0);
    check_traffic("single_beat");
  endtask

  task automatic test_four_beat();
    w_toggle = 1;
    push_burst(32'h2000, 4'd5, 8'd3, -1, 1'b0, 1'b1, 1'b1, 0);
    check_traffic("four_beat");
    w_toggle = 0;
  endtask

  task automatic test_backpressure();
    int budget;
    int p0;
    aw_hold = 1; s_hold = 1;
    p0 = n_pops;
    push_burst(32'h3000, 4'd9, 8'd2, -1, 1'b0, 1'b1, 1'b0, 1);
    budget = 50;
    do begin tick(); budget--; end while (!m_awvalid && budget > 0);
    repeat (4) tick();
    checks++;
    if (n_pops != p0 || m_wvalid !== 1'b0) begin errors++; $display("FAIL backpressure early_pop got pops=%0d wvalid=%b want=%0d/0", n_pops - p0, m_wvalid, 0); end
    aw_hold = 0;
    budget = 100;
    do begin tick(); budget--; end while (!s_bvalid && budget > 0);
    repeat (2) tick();
    s_hold = 0;
    check_traffic("backpressure");
    checks++;
    if (aw_hold_last != 6) begin errors++; $display("FAIL backpressure aw_cycles got=%0d want=6", aw_hold_last); end
    checks++;
    if (s_hold_last != 4) begin errors++; $display("FAIL backpressure s_cycles got=%0d want=4", s_hold_last); end
  endtask

  task automatic test_back_to_back();
    aw_pct = $urandom_range(100, 40);
    w_pct  = $urandom_range(100, 40);
    s_pct  = $urandom_range(100, 40);
    for (int n = 0; n < 12; n++)
      push_burst($urandom, IW'($urandom), 8'($urandom_range(7)), -1, 1'b0, 1'b1, 1'b0, -1);
    check_traffic("back_to_back");
    aw_pct = 100; w_pct = 100; s_pct = 100;
  endtask

  task automatic test_len_mismatch();
    int budget;
    int p0;
    checks++;
    if (len_err !== 1'b0) begin errors++; $display("FAIL len_mismatch pre got=%b want=0", len_err); end
    p0 = n_pops;
    push_burst(32'h4000, 4'd7, 8'd1, 0, 1'b0, 1'b1, 1'b0, -1);
    budget = 50;
    do begin tick(); budget--; end while (n_pops - p0 < 1 && budget > 0);
    checks++;
    if (len_err !== 1'b1 || n_pops - p0 != 1) begin
      errors++; $display("FAIL len_mismatch after_beat0 got len_err=%b pops=%0d want=1/1", len_err, n_pops - p0);
    end
    check_traffic("len_mismatch");
  endtask

  task automatic test_timeout();
    push_burst(32'h5000, 4'd12, 8'd2, -1, 1'b1, 1'b1, 1'b0, 0);
    check_traffic("timeout");
    checks++;
    if (bready_last != BT) begin errors++; $display("FAIL timeout wait_b_cycles got=%0d want=%0d", bready_last, BT); end
    push_burst(32'h5100, 4'd13, 8'd1, -1, 1'b0, 1'b1, 1'b0, -1);
    check_traffic("after_timeout");
  endtask

  task automatic test_reset_mid_data();
    int budget;
    int p0, aw0, w0, b0;
    w_pct = 100;
    p0 = n_pops; aw0 = got_aw.size(); w0 = got_w.size(); b0 = got_b.size();
    push_burst(32'h6000, 4'd2, 8'd3, -1, 1'b0, 1'b0, 1'b0, -1);
    budget = 50;
    do begin tick(); budget--; end while (n_pops - p0 < 2 && budget > 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_awvalid, m_wvalid, ent_ready, m_bready, s_bvalid, busy, len_err, tmo_err} !== 8'b0 || m_awaddr !== '0 || m_awlen !== '0 || s_bresp !== '0) begin
      errors++; $display("FAIL reset_mid ctrl got=%b awaddr=%h awlen=%h want=0", {m_awvalid, m_wvalid, ent_ready, m_bready, s_bvalid, busy, len_err, tmo_err}, m_awaddr, m_awlen);
    end
    flush_req++;
    repeat (3) tick();
    checks++;
    if (n_pops - p0 != 2 || got_aw.size() - aw0 != 1 || got_w.size() - w0 != 2 || got_b.size() != b0) begin
      errors++; $display("FAIL reset_mid activity got pops=%0d aw=%0d w=%0d b=%0d want=2/1/2/0", n_pops - p0, got_aw.size() - aw0, got_w.size() - w0, got_b.size() - b0);
    end
    exp_pops += 2;
    exp_len_err = 1'b0;
    exp_tmo_err = 1'b0;
    off_aw = got_aw.size() - exp_aw.size();
    off_w  = got_w.size() - exp_w.size();
    off_b  = got_b.size() - exp_b.size();
    @(posedge clk);
    #2 rst_n = 1'b1;
    push_burst(32'h7000, 4'd11, 8'd2, -1, 1'b0, 1'b1, 1'b0, -1);
    check_traffic("after_reset");
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_four_beat();
    test_backpressure();
    test_back_to_back();
    test_len_mismatch();
    test_timeout();
    test_reset_mid_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
